// File: rtl/dilithium_kg_ctrl.sv
// dilithium_kg_ctrl: host-side sequencer running one Dilithium keygen (mode 0) per request.
// Ports: req_valid/req_ready/seed_i accept a job and its 256-bit seed; out_* streams core output words
// to the host tagged with segment (0 RHO,1 K,2 S1,3 S2,4 T1,5 T0,6 TR), word index and last flag;
// job_done pulses at completion; busy is high outside IDLE; core_* drive the dilithium core
// (reset, start, mode, seed input stream, output stream). rst_n is asynchronous active-low.
// Optional macro KG_CYCLE_CNT_EN adds cycle_cnt[31:0], the saturating START-to-DONE cycle count.
module dilithium_kg_ctrl #(
  parameter int W = 64,
  parameter int SEC_LEVEL = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [255:0]   seed_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [2:0]     out_seg,
  output logic [9:0]     out_idx,
  output logic           out_last,
  output logic           job_done,
  output logic           busy,
  output logic           core_rst,
  output logic           core_start,
  output logic [1:0]     core_mode,
  output logic           core_valid_i,
  input  logic           core_ready_i,
  output logic [W-1:0]   core_data_i,
  input  logic           core_valid_o,
  output logic           core_ready_o,
  input  logic [W-1:0]   core_data_o
`ifdef KG_CYCLE_CNT_EN
  ,
  output logic [31:0]    cycle_cnt
`endif
);
  localparam int SEED_WORDS = 256 / W;
  typedef enum logic [2:0] {IDLE, CRST, START, SEED, OUT, DONE} state_t;
  state_t state, state_n;
  logic [15:0] cnt;
  logic [255:0] seed_q;
  logic in_xfer, out_xfer, last_seed;
  function automatic logic [9:0] seg_words(input logic [2:0] s);
    int bits;
    bits = (s == 3'd2) ? (SEC_LEVEL == 2 ? 3072 : SEC_LEVEL == 3 ? 5120 : 5376) :
           (s == 3'd3) ? (SEC_LEVEL == 2 ? 3072 : 6144) :
           (s == 3'd4) ? (SEC_LEVEL == 2 ? 10240 : SEC_LEVEL == 3 ? 15360 : 20480) :
           (s == 3'd5) ? (SEC_LEVEL == 2 ? 13312 : SEC_LEVEL == 3 ? 19968 : 26624) : 256;
    return 10'((bits + W - 1) / W);
  endfunction
  assign in_xfer = state == SEED && core_ready_i;
  assign out_xfer = state == OUT && core_valid_o && out_ready;
  assign last_seed = cnt == 16'(SEED_WORDS - 1);
  assign out_last = out_idx == seg_words(out_seg) - 10'd1;
  assign busy = state != IDLE;
  assign core_mode = 2'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // core_rst also follows rst_n directly so the core stays in reset while the controller is.
  always_comb begin
    state_n = state;
    req_ready = 1'b0;
    core_rst = ~rst_n;
    core_start = 1'b0;
    core_valid_i = 1'b0;
    core_data_i = '0;
    out_valid = 1'b0;
    core_ready_o = 1'b0;
    out_data = '0;
    job_done = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) state_n = CRST;
      end
      CRST: begin
        core_rst = 1'b1;
        if (cnt == 16'(RST_CYCLES - 1)) state_n = START;
      end
      START: begin
        core_start = 1'b1;
        state_n = SEED;
      end
      SEED: begin
        core_valid_i = 1'b1;
        core_data_i = seed_q[255 -: W];
        if (core_ready_i && last_seed) state_n = OUT;
      end
      OUT: begin
        out_valid = core_valid_o;
        core_ready_o = out_ready;
        out_data = core_data_o;
        if (out_xfer && out_last && out_seg == 3'd6) state_n = DONE;
      end
      DONE: begin
        job_done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // The seed register shifts left per accepted word so the next word is always at the top.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      seed_q <= '0;
      out_seg <= '0;
      out_idx <= '0;
    end else if (state == IDLE && req_valid) begin
      cnt <= '0;
      seed_q <= seed_i;
      out_seg <= '0;
      out_idx <= '0;
    end else if (state == CRST) begin
      cnt <= (cnt == 16'(RST_CYCLES - 1)) ? '0 : cnt + 16'd1;
    end else if (in_xfer) begin
      cnt <= cnt + 16'd1;
      seed_q <= seed_q << W;
    end else if (out_xfer) begin
      out_idx <= out_last ? '0 : out_idx + 10'd1;
      out_seg <= !out_last ? out_seg : out_seg == 3'd6 ? 3'd0 : out_seg + 3'd1;
    end
`ifdef KG_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cycle_cnt <= '0;
    else if (state == START) cycle_cnt <= '0;
    else if ((state == SEED || state == OUT || state == DONE) && cycle_cnt != 32'hFFFF_FFFF)
      cycle_cnt <= cycle_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_dilithium_kg_ctrl.sv
// tb_dilithium_kg_ctrl: randomized self-checking bench with a behavioural keygen-sequencer model.
module tb_dilithium_kg_ctrl;
  localparam int W = 64;
  localparam int RSTC = 4;
  localparam int NW = 476;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, out_ready = 1'b0;
  logic core_ready_i = 1'b0, core_valid_o = 1'b0;
  logic [255:0] seed_i = '0;
  logic [W-1:0] core_data_o = '0;
  logic req_ready, out_valid, out_last, job_done, busy, core_rst, core_start;
  logic core_valid_i, core_ready_o;
  logic [W-1:0] out_data, core_data_i;
  logic [2:0] out_seg;
  logic [9:0] out_idx;
  logic [1:0] core_mode;
`ifdef KG_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif
  always #5 clk = ~clk;
  dilithium_kg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .seed_i(seed_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_seg(out_seg),
    .out_idx(out_idx), .out_last(out_last), .job_done(job_done), .busy(busy),
    .core_rst(core_rst), .core_start(core_start), .core_mode(core_mode),
    .core_valid_i(core_valid_i), .core_ready_i(core_ready_i), .core_data_i(core_data_i),
    .core_valid_o(core_valid_o), .core_ready_o(core_ready_o), .core_data_o(core_data_o)
`ifdef KG_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic int seg_words(input int s);
    int bits;
    case (s)
      2, 3: bits = 3072;
      4: bits = 10240;
      5: bits = 13312;
      default: bits = 256;
    endcase
    return (bits + W - 1) / W;
  endfunction
  function automatic void seg_of(input int n, output int s, output int idx);
    s = 0;
    idx = n;
    while (s < 6 && idx >= seg_words(s)) begin
      idx -= seg_words(s);
      s++;
    end
  endfunction
  function automatic logic [63:0] word_val(input int salt_v, input int n);
    return {salt_v, n} ^ 64'h9e37_79b9_7f4a_7c15;
  endfunction
  int salt = 0;
  // Behavioural model: the job is a count of reset cycles, a start pulse, seed words and output words.
  logic active = 1'b0, start_seen = 1'b0, chk_cyc = 1'b0;
  logic e_idle, e_rst, e_start, e_vi, e_out, e_done;
  int rst_seen = 0, k = 0, n = 0, cyc = 0, es, ei;
  logic [255:0] exp_seed = '0;
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      active = 1'b0;
      chk_cyc = 1'b0;
    end else begin
      e_idle = !active;
      e_rst = active && rst_seen < RSTC;
      e_start = active && rst_seen == RSTC && !start_seen;
      e_vi = active && start_seen && k < 4;
      e_out = active && k == 4 && n < NW;
      e_done = active && n == NW;
      seg_of(n, es, ei);
      chk("req_ready", req_ready, e_idle);
      chk("busy", busy, active);
      chk("core_rst", core_rst, e_rst);
      chk("core_start", core_start, e_start);
      chk("core_mode", core_mode, 0);
      chk("core_valid_i", core_valid_i, e_vi);
      chk("core_data_i", core_data_i, e_vi ? exp_seed[255 - k * 64 -: 64] : 64'd0);
      chk("out_valid", out_valid, e_out && core_valid_o);
      chk("core_ready_o", core_ready_o, e_out && out_ready);
      chk("job_done", job_done, e_done);
      if (e_out) begin
        chk("out_seg", out_seg, es);
        chk("out_idx", out_idx, ei);
        chk("out_last", out_last, ei == seg_words(es) - 1);
        if (core_valid_o && out_ready) chk("out_data", out_data, word_val(salt, n));
      end
`ifdef KG_CYCLE_CNT_EN
      if (chk_cyc) begin
        chk("cycle_cnt", cycle_cnt, cyc);
        chk_cyc = 1'b0;
      end
`endif
      if (e_rst) rst_seen++;
      if (e_start) begin
        start_seen = 1'b1;
        cyc = 0;
      end else if (active && start_seen) cyc++;
      if (e_vi && core_ready_i) k++;
      if (e_out && core_valid_o && out_ready) n++;
      if (e_done) begin
        active = 1'b0;
        chk_cyc = 1'b1;
      end
      if (e_idle && req_valid) begin
        active = 1'b1;
        rst_seen = 0;
        start_seen = 1'b0;
        k = 0;
        n = 0;
        exp_seed = seed_i;
      end
    end
  end
  // Driver with a simple core model: takes 4 seed words after core_start, then emits NW words.
  logic rnd = 1'b0, cm_armed = 1'b0, done_seen = 1'b0;
  int cm_k = 0, cm_n = 0, bp_cnt = 0, st_cnt = 0;
  int hist[7];
  int exp_cnt[7] = '{4, 4, 48, 48, 160, 208, 4};
  logic [255:0] kat = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
  task automatic step();
    logic prod, stall, bp;
    @(negedge clk);
    prod = cm_armed && cm_k == 4 && cm_n < NW;
    stall = !rnd && cm_armed && cm_k == 1 && st_cnt < 3;
    bp = !rnd && prod && cm_n == 28 && bp_cnt < 5;
    out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    core_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    core_valid_o = prod ? (rnd ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'($urandom_range(0, 1));
    core_data_o = prod ? word_val(salt, cm_n) : {$urandom, $urandom};
    if (stall) begin
      core_ready_i = 1'b0;
      st_cnt++;
    end
    if (bp) begin
      out_ready = 1'b0;
      core_valid_o = 1'b1;
      bp_cnt++;
    end
    #1;
    if (stall) begin
      chk("stall_valid", core_valid_i, 1);
      chk("stall_data", core_data_i, 64'hfedcba9876543210);
    end
    if (bp) begin
      chk("bp_ready", core_ready_o, 0);
      chk("bp_seg", out_seg, 2);
      chk("bp_idx", out_idx, 20);
    end
    if (core_start) begin
      cm_armed = 1'b1;
      cm_k = 0;
      cm_n = 0;
    end
    if (core_valid_i && core_ready_i) cm_k++;
    if (out_valid && out_ready && out_seg < 3'd7) hist[out_seg]++;
    if (core_valid_o && core_ready_o) cm_n++;
    if (job_done) done_seen = 1'b1;
  endtask
  task automatic run_job(input logic [255:0] sd, input logic r, input logic hold, input int abort_at);
    int steps, tot;
    seed_i = sd;
    rnd = r;
    req_valid = 1'b1;
    salt = int'($urandom);
    cm_armed = 1'b0;
    st_cnt = 0;
    bp_cnt = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 7; i++) hist[i] = 0;
    steps = 0;
    while (!done_seen && steps < 6000) begin
      step();
      steps++;
      if (!hold && busy) req_valid = 1'b0;
      if (abort_at >= 0 && cm_n == abort_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_core_rst", core_rst, 1);
        chk("abort_busy", busy, 0);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_core_ready_o", core_ready_o, 0);
        chk("abort_core_valid_i", core_valid_i, 0);
        chk("abort_core_data_i", core_data_i, 0);
        chk("abort_job_done", job_done, 0);
        chk("abort_out_idx", out_idx, 0);
        chk("abort_out_seg", out_seg, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cm_armed = 1'b0;
        req_valid = 1'b0;
        return;
      end
    end
    chk("job_completed", done_seen, 1);
    tot = 0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("seg%0d_words", i), hist[i], exp_cnt[i]);
      tot += hist[i];
    end
    chk("total_words", tot, 476);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", req_ready, 1);
    chk("rel_core_rst", core_rst, 0);
    run_job(kat, 1'b0, 1'b1, -1);
    run_job({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, -1);
    run_job({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 154);
    run_job({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, -1);
    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
